pmem_line_responder: RTL
========================

PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

Interface
REQ-001 The module SHALL provide parameter s_offset, default 5, meaning log2 bytes per cache line.
REQ-002 The module SHALL provide parameter s_beat, default 64, meaning burst beat width in bits.
REQ-003 The module SHALL provide parameter num_beats, default 4, meaning beats per line (s_beat*num_beats = 256).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: pmem_read  input  1  cache line-read request; held until pmem_resp.
REQ-007 Port: pmem_write  input  1  cache line-write request; held until pmem_resp.
REQ-008 Port: pmem_address  input  32  line address from cache.
REQ-009 Port: pmem_wdata  input  256  line write data.
REQ-010 Port: pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-011 Port: pmem_rdata  output  256  assembled read line.
REQ-012 Port: burst_read  output  1  burst-read request to memory.
REQ-013 Port: burst_write  output  1  burst-write request to memory.
REQ-014 Port: burst_address  output  32  line-aligned burst address.
REQ-015 Port: burst_wdata  output  64  current write beat.
REQ-016 Port: burst_rdata  input  64  current read beat.
REQ-017 Port: burst_resp  input  1  per-beat acknowledge; one beat transferred per cycle it is high.

Function
REQ-018 FSM states SHALL be IDLE, READ_BURST, WRITE_BURST, DONE.
REQ-019 IDLE: pmem_write=1 -> latch address/wdata, go WRITE_BURST; else pmem_read=1 -> latch address, go READ_BURST; else stay.
REQ-020 Simultaneous pmem_read and pmem_write in IDLE SHALL be served as a write (write-back priority); read is served only if still asserted after returning to IDLE.
REQ-021 burst_address SHALL equal latched pmem_address with bits [s_offset-1:0] forced to 0, stable for the whole burst.
REQ-022 A 2-bit beat counter SHALL reset to 0 on entering a burst and increment on each cycle burst_resp=1.
REQ-023 READ_BURST: burst_read=1; on burst_resp, burst_rdata SHALL be stored in line bits [64*cnt+63 : 64*cnt].
REQ-024 WRITE_BURST: burst_write=1; burst_wdata SHALL equal latched wdata bits [64*cnt+63 : 64*cnt].
REQ-025 On burst_resp with cnt=num_beats-1, FSM SHALL go DONE; burst_read/burst_write SHALL be 0 in DONE.
REQ-026 DONE: pmem_resp=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 pmem_rdata SHALL be valid in DONE and held unchanged until the next read burst's first beat.
REQ-028 Latency: pmem_resp SHALL assert the cycle after the final beat; minimum request-to-resp = num_beats+1 cycles.
REQ-029 burst_resp low mid-burst SHALL stall with counter and outputs held; no timeout.
REQ-030 Deassertion of pmem_read/pmem_write mid-burst SHALL NOT abort; burst completes and pmem_resp still pulses.
REQ-031 Changes to pmem_address/pmem_wdata after IDLE acceptance SHALL NOT affect the current burst.
REQ-032 burst_resp in IDLE or DONE SHALL be ignored.
REQ-033 pmem_resp SHALL never assert outside DONE; burst_read and burst_write SHALL never both be 1.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, counter 0, pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, pmem_rdata=0, including mid-burst.
REQ-035 After rst deasserts, a request still held SHALL be accepted as a new transaction from IDLE.

Verification
REQ-036 Read: pmem_read, addr 0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> burst_address 0x0000_1220; pmem_resp one cycle after 4th beat; pmem_rdata {0x44..,0x33..,0x22..,0x11..}.
REQ-037 Write: pmem_write, addr 0x8000_00FF, wdata bytes 0x00..0x1F -> burst_address 0x8000_00E0; burst_wdata 0x0706050403020100, then 0x0F0E..08, 0x1716..10, 0x1F1E..18; single pmem_resp.
REQ-038 Stall: burst_resp pattern 1,0,0,1,0,1,1 -> four beats captured correctly; pmem_resp in cycle after 7th pattern cycle.
REQ-039 Simultaneous read+write in IDLE -> burst_write first; after DONE, held pmem_read starts READ_BURST.
REQ-040 rst=0 after 2 read beats -> all outputs 0 asynchronously; no pmem_resp; held pmem_read after release restarts with counter 0.
REQ-041 Address/wdata changed mid-burst -> burst_address and burst_wdata keep latched values.

Source files
------------

// File: rtl/pmem_line_responder_if.sv
// Cache-side line port and memory-side burst port of the line responder.
// The responder uses the slave modport; the cache/memory models use master.
interface pmem_line_responder_if #(
    parameter int s_beat    = 64,
    parameter int num_beats = 4
);
    logic                          pmem_read;
    logic                          pmem_write;
    logic [31:0]                   pmem_address;
    logic [s_beat*num_beats-1:0]   pmem_wdata;
    logic                          pmem_resp;
    logic [s_beat*num_beats-1:0]   pmem_rdata;
    logic                          burst_read;
    logic                          burst_write;
    logic [31:0]                   burst_address;
    logic [s_beat-1:0]             burst_wdata;
    logic [s_beat-1:0]             burst_rdata;
    logic                          burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata,
        output burst_read, burst_write, burst_address, burst_wdata,
        input  burst_rdata, burst_resp
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata,
        input  burst_read, burst_write, burst_address, burst_wdata,
        output burst_rdata, burst_resp
    );
endinterface

// File: rtl/pmem_line_responder.sv
// Converts single cache line read/write requests into num_beats-beat memory
// bursts; writes win over simultaneous reads, and pmem_resp pulses once per line.
module pmem_line_responder #(
    parameter int s_offset  = 5,
    parameter int s_beat    = 64,
    parameter int num_beats = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pmem_line_responder_if.slave bus
);
    localparam int line_w = s_beat * num_beats;
    localparam int cnt_w  = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        READ_BURST,
        WRITE_BURST,
        DONE
    } state_t;

    state_t             state;
    logic [cnt_w-1:0]   cnt;
    logic [cnt_w-1:0]   cnt_next;
    logic               last_beat;
    logic [line_w-1:0]  wdata_q;

    assign cnt_next  = cnt + cnt_w'(1);
    assign last_beat = (cnt == cnt_w'(num_beats - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            wdata_q           <= '0;
            bus.pmem_resp     <= 1'b0;
            bus.pmem_rdata    <= '0;
            bus.burst_read    <= 1'b0;
            bus.burst_write   <= 1'b0;
            bus.burst_address <= '0;
            bus.burst_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.pmem_resp <= 1'b0;
                    cnt           <= '0;
                    if (bus.pmem_write) begin
                        wdata_q           <= bus.pmem_wdata;
                        bus.burst_address <= bus.pmem_address & ~off_mask;
                        bus.burst_wdata   <= bus.pmem_wdata[s_beat-1:0];
                        bus.burst_write   <= 1'b1;
                        state             <= WRITE_BURST;
                    end else if (bus.pmem_read) begin
                        bus.burst_address <= bus.pmem_address & ~off_mask;
                        bus.burst_read    <= 1'b1;
                        state             <= READ_BURST;
                    end
                end

                READ_BURST: begin
                    if (bus.burst_resp) begin
                        bus.pmem_rdata[cnt*s_beat +: s_beat] <= bus.burst_rdata;
                        if (last_beat) begin
                            bus.burst_read <= 1'b0;
                            bus.pmem_resp  <= 1'b1;
                            state          <= DONE;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                end

                WRITE_BURST: begin
                    // burst_wdata is preloaded with the next beat so it is valid
                    // in the same cycle the counter advances.
                    if (bus.burst_resp) begin
                        if (last_beat) begin
                            bus.burst_write <= 1'b0;
                            bus.pmem_resp   <= 1'b1;
                            state           <= DONE;
                        end else begin
                            cnt             <= cnt_next;
                            bus.burst_wdata <= wdata_q[cnt_next*s_beat +: s_beat];
                        end
                    end
                end

                DONE: begin
                    bus.pmem_resp <= 1'b0;
                    cnt           <= '0;
                    state         <= IDLE;
                end

                default: begin
                    bus.pmem_resp   <= 1'b0;
                    bus.burst_read  <= 1'b0;
                    bus.burst_write <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule
